// File: rtl/vga_timing_gen_if.sv
// Raster bus from the VGA timing generator to the renderer and game logic.
// The timing generator drives it through the master modport.
interface vga_timing_gen_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        bright;
    logic        pix_en;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output hcount, vcount, hsync, vsync, bright,
        output pix_en, line_tick, frame_tick, frame_count
    );

    modport slave (
        input hcount, vcount, hsync, vsync, bright,
        input pix_en, line_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, h/v counters, registered sync/bright decode,
// pixel strobe, line/frame ticks and a free-running frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_VIS_LO = H_SYNC + H_BP;
    localparam int H_VIS_HI = H_VIS_LO + H_ACTIVE;
    localparam int V_VIS_LO = V_SYNC + V_BP;
    localparam int V_VIS_HI = V_VIS_LO + V_ACTIVE;
    // A one-clock divider still needs a 1-bit counter that never leaves 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    function automatic logic in_span(input logic [9:0] x, input int lo, input int hi);
        return (x >= 10'(lo)) && (x < 10'(hi));
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       hcount_p0, vcount_p0;
    logic             hsync_p0, vsync_p0, bright_p0;
    logic             pix_en_p0, line_tick_p0, frame_tick_p0;
    logic [15:0]      frame_cnt_p0;

    logic             advance, h_wrap, v_wrap;
    logic [9:0]       h_nxt, v_nxt;

    assign advance = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        h_wrap = (hcount_p0 == 10'(H_TOTAL - 1));
        v_wrap = (vcount_p0 == 10'(V_TOTAL - 1));
        h_nxt  = h_wrap ? 10'd0 : hcount_p0 + 10'd1;
        v_nxt  = vcount_p0;
        if (h_wrap)
            v_nxt = v_wrap ? 10'd0 : vcount_p0 + 10'd1;
    end

    // Counters and decodes update together on the advance edge, decoded from the new position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt       <= '0;
            hcount_p0     <= '0;
            vcount_p0     <= '0;
            hsync_p0      <= 1'b1;
            vsync_p0      <= 1'b1;
            bright_p0     <= 1'b0;
            pix_en_p0     <= 1'b0;
            line_tick_p0  <= 1'b0;
            frame_tick_p0 <= 1'b0;
            frame_cnt_p0  <= '0;
        end else begin
            div_cnt       <= advance ? '0 : div_cnt + 1'b1;
            pix_en_p0     <= advance;
            line_tick_p0  <= advance && h_wrap;
            frame_tick_p0 <= advance && h_wrap && v_wrap;
            if (advance) begin
                hcount_p0 <= h_nxt;
                vcount_p0 <= v_nxt;
                hsync_p0  <= !(h_nxt < 10'(H_SYNC));
                vsync_p0  <= !(v_nxt < 10'(V_SYNC));
                bright_p0 <= in_span(h_nxt, H_VIS_LO, H_VIS_HI) && in_span(v_nxt, V_VIS_LO, V_VIS_HI);
                if (h_wrap && v_wrap)
                    frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
            end
        end
    end

    assign vga.hcount      = hcount_p0;
    assign vga.vcount      = vcount_p0;
    assign vga.hsync       = hsync_p0;
    assign vga.vsync       = vsync_p0;
    assign vga.bright      = bright_p0;
    assign vga.pix_en      = pix_en_p0;
    assign vga.line_tick   = line_tick_p0;
    assign vga.frame_tick  = frame_tick_p0;
    assign vga.frame_count = frame_cnt_p0;
endmodule
